// File: rtl/spsram_arb2.sv
// Round-robin arbiter sharing one single-port SRAM (1-cycle registered read)
// between two requesters; read data returns to the owner one cycle after grant.
module spsram_arb2 #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    logic prio_q, prio_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic both;

    always_comb begin
        both   = m0_req & m1_req;
        m0_gnt = ~rst & m0_req & (~m1_req | ~prio_q);
        m1_gnt = ~rst & m1_req & (~m0_req | prio_q);

        sram_cs   = m0_gnt | m1_gnt;
        sram_we   = m1_gnt ? m1_we : (m0_gnt & m0_we);
        sram_addr = m1_gnt ? m1_addr : m0_addr;
        sram_din  = m1_gnt ? m1_wdata : m0_wdata;

        // pointer moves to the loser only when both were contending
        prio_d     = both ? m0_gnt : prio_q;
        rd_pend_d  = sram_cs & ~sram_we;
        rd_owner_d = rd_pend_d ? m1_gnt : rd_owner_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = ~rst & rd_pend_q & ~rd_owner_q;
    assign m1_rvalid = ~rst & rd_pend_q & rd_owner_q;
    assign m0_rdata  = sram_dout;
    assign m1_rdata  = sram_dout;

endmodule

// File: tb/tb_spsram_arb2.sv
// Bench for spsram_arb2: SRAM model, spec-level reference model with
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_spsram_arb2;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 0;
    logic          rst = 1;
    logic          m0_req = 0, m0_we = 0;
    logic [AW-1:0] m0_addr = 0;
    logic [DW-1:0] m0_wdata = 0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 0, m1_we = 0;
    logic [AW-1:0] m1_addr = 0;
    logic [DW-1:0] m1_wdata = 0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = 0;

    int n_chk = 0;
    int n_pass = 0;

    spsram_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM device model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // reference model: turn-based priority, word memory, pending read slot
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            turn = 0;
    bit            pend = 0;
    int            owner = 0;
    logic [DW-1:0] pend_data = 0;
    int            w0 = 0, w1 = 0;

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
    end

    always @(negedge clk) begin
        bit e0, e1;
        if (rst) begin
            chk("rst_gnt0", m0_gnt, 0);
            chk("rst_gnt1", m1_gnt, 0);
            chk("rst_cs", sram_cs, 0);
            chk("rst_we", sram_we, 0);
            chk("rst_rv0", m0_rvalid, 0);
            chk("rst_rv1", m1_rvalid, 0);
            turn = 0; pend = 0; owner = 0; w0 = 0; w1 = 0;
        end else begin
            e0 = m0_req && (!m1_req || turn == 0);
            e1 = m1_req && !e0;
            chk("gnt0", m0_gnt, e0);
            chk("gnt1", m1_gnt, e1);
            chk("one_gnt", m0_gnt & m1_gnt, 0);
            chk("cs", sram_cs, e0 | e1);
            if (e0) begin
                chk("we0", sram_we, m0_we);
                chk("addr0", sram_addr, m0_addr);
                if (m0_we) chk("din0", sram_din, m0_wdata);
            end else if (e1) begin
                chk("we1", sram_we, m1_we);
                chk("addr1", sram_addr, m1_addr);
                if (m1_we) chk("din1", sram_din, m1_wdata);
            end else begin
                chk("we_idle", sram_we, 0);
            end
            chk("rv0", m0_rvalid, pend && owner == 0);
            chk("rv1", m1_rvalid, pend && owner == 1);
            if (pend && owner == 0) chk("rdata0", m0_rdata, pend_data);
            if (pend && owner == 1) chk("rdata1", m1_rdata, pend_data);
            w0 = (m0_req && !m0_gnt) ? w0 + 1 : 0;
            w1 = (m1_req && !m1_gnt) ? w1 + 1 : 0;
            if (m0_req && m1_req) begin
                chk("wait0", w0 > 1, 0);
                chk("wait1", w1 > 1, 0);
            end
            if (m0_req && m1_req) turn = e0 ? 1 : 0;
            pend = 0;
            if (e0) begin
                if (m0_we) ref_mem[m0_addr] = m0_wdata;
                else begin pend = 1; owner = 0; pend_data = ref_mem[m0_addr]; end
            end else if (e1) begin
                if (m1_we) ref_mem[m1_addr] = m1_wdata;
                else begin pend = 1; owner = 1; pend_data = ref_mem[m1_addr]; end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        bit g0, g1;
        // 1: reset holds everything off even with both requesting
        drv0(1, 0, 10'h001, 0);
        drv1(1, 0, 10'h002, 0);
        step();
        @(negedge clk);
        chk("t1_gnt0", m0_gnt, 0);
        chk("t1_gnt1", m1_gnt, 0);
        chk("t1_cs", sram_cs, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("t1_first", {m1_gnt, m0_gnt}, 2'b01);
        // 2: write then read back on consecutive cycles
        step();
        drv1(0, 0, 0, 0);
        drv0(1, 1, 10'h005, 32'hDEADBEEF);
        @(negedge clk);
        chk("t2_wgnt", m0_gnt, 1);
        step();
        drv0(1, 0, 10'h005, 0);
        step();
        drv0(0, 0, 0, 0);
        @(negedge clk);
        chk("t2_rv0", m0_rvalid, 1);
        chk("t2_rd", m0_rdata, 32'hDEADBEEF);
        chk("t2_rv1", m1_rvalid, 0);
        // 3: preload, reset pointer, then continuous contention
        step();
        drv0(1, 1, 10'h010, 32'h11110010);
        step();
        drv0(0, 0, 0, 0);
        drv1(1, 1, 10'h020, 32'h22220020);
        step();
        drv1(0, 0, 0, 0);
        rst = 1;
        step();
        rst = 0;
        drv0(1, 0, 10'h010, 0);
        drv1(1, 0, 10'h020, 0);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin drv0(0, 0, 0, 0); drv1(0, 0, 0, 0); end
            @(negedge clk);
            if (i < 6)
                chk($sformatf("t3_g%0d", i), {m1_gnt, m0_gnt},
                    (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                if (i % 2 == 1) begin
                    chk("t3_rv0", m0_rvalid, 1);
                    chk("t3_rd0", m0_rdata, 32'h11110010);
                end else begin
                    chk("t3_rv1", m1_rvalid, 1);
                    chk("t3_rd1", m1_rdata, 32'h22220020);
                end
            end
            step();
        end
        // 4: m1 alone three times, then contention goes to m0
        drv1(1, 0, 10'h020, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_m1", {m1_gnt, m0_gnt}, 2'b10);
            step();
        end
        drv0(1, 0, 10'h010, 0);
        @(negedge clk);
        chk("t4_both", {m1_gnt, m0_gnt}, 2'b01);
        step();
        drv0(0, 0, 0, 0);
        drv1(0, 0, 0, 0);
        step();
        // 5: reset right after an m1 read grant kills the response
        drv1(1, 1, 10'h033, 32'hCAFEF00D);
        step();
        drv1(1, 0, 10'h033, 0);
        @(negedge clk);
        chk("t5_gnt", m1_gnt, 1);
        step();
        drv1(0, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("t5_rv_rst", m1_rvalid, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("t5_rv_post", m1_rvalid, 0);
        step();
        drv1(1, 0, 10'h033, 0);
        step();
        drv1(0, 0, 0, 0);
        @(negedge clk);
        chk("t5_rv", m1_rvalid, 1);
        chk("t5_rd", m1_rdata, 32'hCAFEF00D);
        // 6: random mixed traffic, requests held until granted
        g0 = 1; g1 = 1;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (g0 || !m0_req)
                drv0($urandom_range(3) != 0, $urandom_range(1),
                     AW'($urandom_range(15)), $urandom);
            if (g1 || !m1_req)
                drv1($urandom_range(3) != 0, $urandom_range(1),
                     AW'($urandom_range(15)), $urandom);
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
        end
        step();
        drv0(0, 0, 0, 0);
        drv1(0, 0, 0, 0);
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
